// File: rtl/sound_arbiter_if.sv
// Signal bundle between game-logic event sources and the sound arbiter.
// req is a set of single-cycle event pulses sampled on every rising edge; there is no
// backpressure. All arbiter outputs are registered and valid in every cycle after reset.
interface sound_arbiter_if;
    logic [3:0] req;
    logic       mute;
    logic       soundEnable;
    logic [3:0] Tone;
    logic       busy;
    logic [1:0] active_src;
    logic [1:0] state_dbg;
    logic [3:0] pending_dbg;

    modport master (
        output req, mute,
        input  soundEnable, Tone, busy, active_src, state_dbg, pending_dbg
    );

    modport slave (
        input  req, mute,
        output soundEnable, Tone, busy, active_src, state_dbg, pending_dbg
    );
endinterface

// File: rtl/sound_arbiter.sv
// Fixed-priority, preemptive arbiter that shares one tone generator among four sound events
// and plays each source's short note pattern on registered soundEnable/Tone outputs.
module sound_arbiter #(
    parameter int unsigned NOTE_CYCLES = 5000000,
    parameter int unsigned GAP_CYCLES  = 500000
) (
    input logic           clk,
    input logic           resetN,
    sound_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_GAP = 2'd2} state_t;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  note_q, note_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  src_q, src_d;
    logic        se_q, se_d;
    logic [3:0]  tone_q, tone_d;
    logic        busy_q, busy_d;
    logic [1:0]  req_hi;
    logic [1:0]  grant;
    logic        restart;

    function automatic logic [1:0] hi_bit(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    function automatic logic [1:0] last_note(input logic [1:0] s);
        case (s)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            2'd2:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [3:0] pat_tone(input logic [1:0] s, input logic [1:0] n);
        case ({s, n})
            4'b00_00: return 4'd9;
            4'b01_00: return 4'd6;
            4'b01_01: return 4'd4;
            4'b10_00: return 4'd3;
            4'b10_01: return 4'd1;
            4'b11_00: return 4'd7;
            4'b11_01: return 4'd5;
            4'b11_10: return 4'd3;
            default:  return 4'd0;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | bus.req;
        note_d    = note_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        req_hi    = hi_bit(bus.req);
        grant     = 2'd0;
        // A request at or above the active source's priority restarts playback; equal means retrigger.
        restart   = (bus.req != 4'd0) && (req_hi >= src_q);

        case (state_q)
            ST_IDLE: begin
                if ((pending_q | bus.req) != 4'd0) begin
                    grant            = hi_bit(pending_q | bus.req);
                    state_d          = ST_PLAY;
                    note_d           = 2'd0;
                    cnt_d            = 32'd0;
                    src_d            = grant;
                    pending_d[grant] = 1'b0;
                end
            end
            ST_PLAY, ST_GAP: begin
                pending_d[src_q] = 1'b0;
                if (restart) begin
                    state_d           = ST_PLAY;
                    note_d            = 2'd0;
                    cnt_d             = 32'd0;
                    src_d             = req_hi;
                    pending_d[req_hi] = 1'b0;
                end else if (state_q == ST_PLAY) begin
                    if (cnt_q == NOTE_LAST) begin
                        cnt_d = 32'd0;
                        if (note_q != last_note(src_q)) begin
                            state_d = ST_GAP;
                            note_d  = note_q + 2'd1;
                        end else if (pending_d != 4'd0) begin
                            // Hand straight to the next waiting source without an idle cycle.
                            grant            = hi_bit(pending_d);
                            state_d          = ST_PLAY;
                            note_d           = 2'd0;
                            src_d            = grant;
                            pending_d[grant] = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            note_d  = 2'd0;
                            src_d   = 2'd0;
                        end
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = ST_PLAY;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                note_d  = 2'd0;
                cnt_d   = 32'd0;
                src_d   = 2'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        se_d   = (state_d == ST_PLAY) && !bus.mute;
        tone_d = (state_d == ST_PLAY) ? pat_tone(src_d, note_d) : 4'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'd0;
            note_q    <= 2'd0;
            cnt_q     <= 32'd0;
            src_q     <= 2'd0;
            se_q      <= 1'b0;
            tone_q    <= 4'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            note_q    <= note_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            se_q      <= se_d;
            tone_q    <= tone_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.soundEnable = se_q;
    assign bus.Tone        = tone_q;
    assign bus.busy        = busy_q;
    assign bus.active_src  = src_q;
    assign bus.state_dbg   = state_q;
    assign bus.pending_dbg = pending_q;
endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: expected output segments (start, length, state, source,
// tone, enable) are queued with the stimulus and matched by an independent output monitor.
module tb_sound_arbiter;
    localparam int N = 10;
    localparam int G = 3;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [33:0] exp_q[$];

    sound_arbiter_if bus();

    sound_arbiter #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    // ---------------- clock / cycle counter / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Segment word: start[16] len[8] busy state[2] src[2] tone[4] se
    function automatic logic [33:0] seg(input int start, input int len, input int st,
                                        input int src, input int tone, input int se);
        return {16'(start), 8'(len), 1'b1, 2'(st), 2'(src), 4'(tone), 1'(se)};
    endfunction

    function automatic string seg_str(input logic [33:0] s);
        return $sformatf("start=%0d len=%0d busy=%0d st=%0d src=%0d tone=%0d se=%0d",
                         s[33:18], s[17:10], s[9], s[8:7], s[6:5], s[4:1], s[0]);
    endfunction

    task automatic compare_seg(input logic [33:0] act);
        logic [33:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL seg_unexpected: got %s, expected none", seg_str(act));
        end else begin
            e = exp_q.pop_front();
            if (e != act) begin
                n_fail++;
                $display("FAIL seg: got %s, expected %s", seg_str(act), seg_str(e));
            end
        end
    endtask

    // Expected segments of one full pattern starting at 'start'; returns the first free cycle.
    task automatic exp_pattern(input int src, input int start, input int se, output int nxt);
        int t[4];
        int last;
        int s;
        case (src)
            0:       begin t = '{9, 0, 0, 0}; last = 0; end
            1:       begin t = '{6, 4, 0, 0}; last = 1; end
            2:       begin t = '{3, 1, 0, 0}; last = 1; end
            default: begin t = '{7, 5, 3, 0}; last = 3; end
        endcase
        s = start;
        for (int i = 0; i <= last; i++) begin
            exp_q.push_back(seg(s, N, 1, src, t[i], se));
            s += N;
            if (i < last) begin
                exp_q.push_back(seg(s, G, 2, src, 0, 0));
                s += G;
            end
        end
        nxt = s;
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [9:0] key;
        logic [9:0] prev;
        int rs;
        int rl;
        bit rv;
        prev = '0;
        rv = 1'b0;
        rs = 0;
        rl = 0;
        forever begin
            @(negedge clk);
            key = {bus.busy, bus.state_dbg, bus.active_src, bus.Tone, bus.soundEnable};
            if (rv && key == prev) begin
                rl++;
            end else begin
                if (rv && prev != 10'd0) compare_seg({16'(rs), 8'(rl), prev});
                rv = 1'b1;
                prev = key;
                rs = cyc;
                rl = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic to_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_at(input int t, input logic [3:0] v);
        to_cycle(t);
        bus.req = v;
        @(posedge clk);
        #1;
        bus.req = 4'd0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.busy && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, int'(bus.busy), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int nx;
        bus.req = 4'd0;
        bus.mute = 1'b0;
        resetN = 1'b0;
        #2;
        check("rst_se", int'(bus.soundEnable), 0);
        check("rst_tone", int'(bus.Tone), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_src", int'(bus.active_src), 0);
        check("rst_state", int'(bus.state_dbg), 0);
        check("rst_pending", int'(bus.pending_dbg), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // Single shoot: 10 cycles of tone 9, latency 1.
        c = cyc + 2;
        exp_q.push_back(seg(c + 1, 10, 1, 0, 9, 1));
        pulse_at(c, 4'b0001);
        wait_idle("shoot_idle");

        // Game over: four notes with gaps, 49 busy cycles.
        c = cyc + 2;
        exp_pattern(3, c + 1, 1, nx);
        pulse_at(c, 4'b1000);
        wait_idle("gameover_idle");

        // Preemption: shoot cut after 4 cycles by player hit; shoot is not resumed.
        c = cyc + 2;
        exp_q.push_back(seg(c + 1, 4, 1, 0, 9, 1));
        exp_pattern(2, c + 5, 1, nx);
        pulse_at(c, 4'b0001);
        pulse_at(c + 4, 4'b0100);
        wait_idle("preempt_idle");

        // Pending service: shoot waits behind player hit, then follows with no idle cycle.
        c = cyc + 2;
        exp_pattern(2, c + 1, 1, nx);
        exp_pattern(0, nx, 1, nx);
        pulse_at(c, 4'b0100);
        pulse_at(c + 2, 4'b0001);
        wait_idle("pending_idle");

        // Simultaneous requests served in priority order.
        c = cyc + 2;
        exp_pattern(2, c + 1, 1, nx);
        exp_pattern(1, nx, 1, nx);
        exp_pattern(0, nx, 1, nx);
        pulse_at(c, 4'b0111);
        wait_idle("simul_idle");

        // Retrigger: second src2 pulse restarts note 0, first note run stretches to 15 cycles.
        c = cyc + 2;
        exp_q.push_back(seg(c + 1, 15, 1, 2, 3, 1));
        exp_q.push_back(seg(c + 16, 3, 2, 2, 0, 0));
        exp_q.push_back(seg(c + 19, 10, 1, 2, 1, 1));
        pulse_at(c, 4'b0100);
        pulse_at(c + 5, 4'b0100);
        wait_idle("retrig_idle");

        // Mute: tones still sequence, enable held low.
        bus.mute = 1'b1;
        c = cyc + 2;
        exp_pattern(3, c + 1, 0, nx);
        pulse_at(c, 4'b1000);
        wait_idle("mute_idle");
        bus.mute = 1'b0;

        // Reset mid-note with shoot pending: everything clears, shoot never plays.
        c = cyc + 2;
        exp_q.push_back(seg(c + 1, 4, 1, 2, 3, 1));
        pulse_at(c, 4'b0100);
        pulse_at(c + 2, 4'b0001);
        to_cycle(c + 5);
        #1;
        resetN = 1'b0;
        #1;
        check("midrst_se", int'(bus.soundEnable), 0);
        check("midrst_tone", int'(bus.Tone), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_src", int'(bus.active_src), 0);
        check("midrst_pending", int'(bus.pending_dbg), 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("postrst_pending", int'(bus.pending_dbg), 0);
        check("postrst_busy", int'(bus.busy), 0);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("exp_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
